// File: rtl/decoder_bus_arbiter.sv
// Round-robin arbiter driving a shared 2-to-4 active-low decoded select bus.
// Latency: grant visible one edge after REQ is sampled; one GAP cycle after each release.
// Backpressure: none; a grant ends when the owner drops REQ or after MAX_HOLD cycles.
module decoder_bus_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [0:3] REQ,
  output logic [0:3] GNT,
  output logic [0:3] SEL_N,
  output logic       X,
  output logic       Y,
  output logic       Z,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Counter value during the last visible cycle of a maximum-length grant.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q;
  logic [1:0]       owner_q;
  logic [1:0]       ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [0:3]       gnt_q;
  logic             x_q;
  logic             y_q;
  logic             z_q;
  logic             busy_q;

  logic             found_d;
  logic [1:0]       pick_d;
  logic [0:3]       pick_gnt_d;
  logic             release_d;

  // Pick the first requester at or after the priority pointer, wrapping mod 4.
  always_comb begin
    found_d    = 1'b0;
    pick_d     = ptr_q;
    pick_gnt_d = '0;
    for (int k = 0; k < 4; k++) begin
      if (!found_d && REQ[ptr_q + 2'(k)]) begin
        found_d = 1'b1;
        pick_d  = ptr_q + 2'(k);
      end
    end
    pick_gnt_d[pick_d] = 1'b1;
  end

  // Owner ends its grant by dropping its request or by exhausting its hold budget.
  always_comb begin
    release_d = !REQ[owner_q] || (cnt_q == HOLD_LAST);
  end

  // Arbitration FSM; every output is a register so REQ never reaches a pin combinationally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      z_q     <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_GRANT: begin
          cnt_q <= cnt_q + 1'b1;
          if (release_d) begin
            // Moving the pointer past the owner keeps a persistent requester from starving others.
            state_q <= S_GAP;
            ptr_q   <= owner_q + 2'd1;
            gnt_q   <= '0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            z_q     <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          // IDLE and GAP arbitrate identically; GAP only differs in having BUSY high.
          if (found_d) begin
            state_q <= S_GRANT;
            owner_q <= pick_d;
            cnt_q   <= '0;
            gnt_q   <= pick_gnt_d;
            x_q     <= pick_d[1];
            y_q     <= pick_d[0];
            z_q     <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            z_q     <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign GNT   = gnt_q;
  assign SEL_N = ~gnt_q;
  assign X     = x_q;
  assign Y     = y_q;
  assign Z     = z_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_decoder_bus_arbiter.sv
// Bench for decoder_bus_arbiter: directed vector table plus hand-written multi-cycle sequences.
// Three instances cover MAX_HOLD = 4, 2 and 1.
module tb_decoder_bus_arbiter;

  logic       CLK;
  logic       RST_N;

  logic [0:3] req_a, gnt_a, sel_a;
  logic       x_a, y_a, z_a, busy_a;
  logic [0:3] req_b, gnt_b, sel_b;
  logic       x_b, y_b, z_b, busy_b;
  logic [0:3] req_c, gnt_c, sel_c;
  logic       x_c, y_c, z_c, busy_c;

  int vec_cnt;
  int err_cnt;
  bit mon_en;

  decoder_bus_arbiter #(.MAX_HOLD(4), .CNT_W(8)) u_dut_a (
    .CLK(CLK), .RST_N(RST_N), .REQ(req_a), .GNT(gnt_a), .SEL_N(sel_a),
    .X(x_a), .Y(y_a), .Z(z_a), .BUSY(busy_a)
  );

  decoder_bus_arbiter #(.MAX_HOLD(2), .CNT_W(8)) u_dut_b (
    .CLK(CLK), .RST_N(RST_N), .REQ(req_b), .GNT(gnt_b), .SEL_N(sel_b),
    .X(x_b), .Y(y_b), .Z(z_b), .BUSY(busy_b)
  );

  decoder_bus_arbiter #(.MAX_HOLD(1), .CNT_W(4)) u_dut_c (
    .CLK(CLK), .RST_N(RST_N), .REQ(req_c), .GNT(gnt_c), .SEL_N(sel_c),
    .X(x_c), .Y(y_c), .Z(z_c), .BUSY(busy_c)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [0:3] req;
    logic [0:3] gnt;
    logic       x;
    logic       y;
    logic       z;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [0:3] req, input logic [0:3] gnt, input logic x,
                     input logic y, input logic z, input logic busy);
    vec_t v;
    v.req = req; v.gnt = gnt; v.x = x; v.y = y; v.z = z; v.busy = busy;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [0:3] ag, input logic [0:3] asel,
                     input logic ax, input logic ay, input logic az, input logic ab,
                     input logic [0:3] eg, input logic ex, input logic ey,
                     input logic ez, input logic eb);
    logic [0:3] esel;
    esel = ~eg;
    vec_cnt++;
    if (ag !== eg || asel !== esel || ax !== ex || ay !== ey || az !== ez || ab !== eb) begin
      err_cnt++;
      $display("FAIL %s: got GNT=%b SEL_N=%b X=%b Y=%b Z=%b BUSY=%b, want GNT=%b SEL_N=%b X=%b Y=%b Z=%b BUSY=%b",
               nm, ag, asel, ax, ay, az, ab, eg, esel, ex, ey, ez, eb);
    end
  endtask

  task automatic chk_inv(input string nm, input logic [0:3] g, input logic [0:3] s,
                         input logic x, input logic y, input logic z);
    logic [1:0] idx;
    logic       ok;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) idx = 2'(i);
    ok = ($countones(g) <= 1) && (s === ~g) && (z === ~(|g)) && ({x, y} === idx);
    vec_cnt++;
    if (!ok) begin
      err_cnt++;
      $display("FAIL %s invariant: got GNT=%b SEL_N=%b X=%b Y=%b Z=%b, want consistent decode",
               nm, g, s, x, y, z);
    end
  endtask

  // Output decode invariants on every instance, sampled mid-cycle.
  always @(negedge CLK) begin
    if (mon_en) begin
      chk_inv("inv_a", gnt_a, sel_a, x_a, y_a, z_a);
      chk_inv("inv_b", gnt_b, sel_b, x_b, y_b, z_b);
      chk_inv("inv_c", gnt_c, sel_c, x_c, y_c, z_c);
    end
  end

  initial begin
    logic [0:3] eg;
    int         own;
    vec_cnt = 0;
    err_cnt = 0;
    mon_en  = 1'b0;
    RST_N   = 1'b0;
    req_a   = 4'b0000;
    req_b   = 4'b0000;
    req_c   = 4'b0000;

    // Idle for 5 cycles
    repeat (5) add(4'b0000, 4'b0000, 0, 0, 1, 0);
    // Requester 1 for three samples, then dropped: grant, GAP, IDLE
    add(4'b0100, 4'b0100, 0, 1, 0, 1);
    add(4'b0100, 4'b0100, 0, 1, 0, 1);
    add(4'b0100, 4'b0100, 0, 1, 0, 1);
    add(4'b0000, 4'b0000, 0, 0, 1, 1);
    add(4'b0000, 4'b0000, 0, 0, 1, 0);
    // Requester 2 held: 4-cycle grant, GAP, re-grant for another 4
    repeat (4) add(4'b0010, 4'b0010, 1, 0, 0, 1);
    add(4'b0010, 4'b0000, 0, 0, 1, 1);
    repeat (4) add(4'b0010, 4'b0010, 1, 0, 0, 1);
    add(4'b0010, 4'b0000, 0, 0, 1, 1);
    add(4'b0000, 4'b0000, 0, 0, 1, 0);
    // Requester 0 granted, requester 2 arrives mid-grant, 0 hits hold limit -> 2 next
    add(4'b1000, 4'b1000, 0, 0, 0, 1);
    add(4'b1010, 4'b1000, 0, 0, 0, 1);
    add(4'b1010, 4'b1000, 0, 0, 0, 1);
    add(4'b1010, 4'b1000, 0, 0, 0, 1);
    add(4'b1010, 4'b0000, 0, 0, 1, 1);
    add(4'b1010, 4'b0010, 1, 0, 0, 1);
    // Owner 2 drops while 0 keeps requesting: grant ends at once, then 0 served
    add(4'b1000, 4'b0000, 0, 0, 1, 1);
    add(4'b1000, 4'b1000, 0, 0, 0, 1);
    add(4'b0000, 4'b0000, 0, 0, 1, 1);
    add(4'b0000, 4'b0000, 0, 0, 1, 0);
    // Pointer now at 1: REQ=1001 goes to requester 3
    add(4'b1001, 4'b0001, 1, 1, 0, 1);

    #12;
    chk("reset_a", gnt_a, sel_a, x_a, y_a, z_a, busy_a, 4'b0000, 0, 0, 1, 0);
    chk("reset_b", gnt_b, sel_b, x_b, y_b, z_b, busy_b, 4'b0000, 0, 0, 1, 0);
    RST_N  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      req_a = tbl[i].req;
      tick();
      chk($sformatf("vec%0d", i), gnt_a, sel_a, x_a, y_a, z_a, busy_a,
          tbl[i].gnt, tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].busy);
    end

    // Asynchronous reset between edges while requester 3 holds the grant
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst", gnt_a, sel_a, x_a, y_a, z_a, busy_a, 4'b0000, 0, 0, 1, 0);
    #1 RST_N = 1'b1;
    tick();
    chk("post_rst_ptr0", gnt_a, sel_a, x_a, y_a, z_a, busy_a, 4'b1000, 0, 0, 0, 1);
    req_a = 4'b0000;

    // Round robin with all requesting, MAX_HOLD=2: 2 grant cycles + 1 GAP per requester
    req_b = 4'b1111;
    req_c = 4'b0100;
    for (int c = 0; c < 24; c++) begin
      tick();
      own = (c / 3) % 4;
      eg  = 4'b0000;
      if ((c % 3) != 2) eg[own] = 1'b1;
      chk($sformatf("rr%0d", c), gnt_b, sel_b, x_b, y_b, z_b, busy_b, eg,
          ((c % 3) != 2) ? own[1] : 1'b0, ((c % 3) != 2) ? own[0] : 1'b0,
          ((c % 3) == 2), 1'b1);
      // MAX_HOLD=1 with requester 1 held: alternate grant / GAP
      if ((c % 2) == 0)
        chk($sformatf("mh1_%0d", c), gnt_c, sel_c, x_c, y_c, z_c, busy_c, 4'b0100, 0, 1, 0, 1);
      else
        chk($sformatf("mh1_%0d", c), gnt_c, sel_c, x_c, y_c, z_c, busy_c, 4'b0000, 0, 0, 1, 1);
    end
    req_b = 4'b0000;
    req_c = 4'b0000;
    tick();
    tick();
    chk("rr_idle", gnt_b, sel_b, x_b, y_b, z_b, busy_b, 4'b0000, 0, 0, 1, 0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
